alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Operand-fetch and issue stage that sits directly upstream of yAlu and feeds its a, b and op inputs. It holds the 32x32 integer register file and decodes RV32I R-type and I-type ALU instructions into the 3-bit ALU op. A per-register pending scoreboard blocks read-after-write and write-after-write hazards until the ALU result is written back. Issued operands are held in a single-entry output register with a valid/ready handshake.

Parameters:
XLEN, 32, datapath and register width.
STALL_CW, 16, width of the stall counter (used only with the optional feature).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  in_inst is valid.
in_ready  out  1  stage accepts in_inst this cycle.
in_inst  in  32  RV32I instruction word.
wb_en  in  1  writeback strobe from the downstream stage.
wb_rd  in  5  writeback destination register.
wb_data  in  XLEN  writeback value.
out_valid  out  1  output register holds an issued instruction.
out_ready  in  1  ALU side consumes the output register.
out_a  out  XLEN  operand a for yAlu.
out_b  out  XLEN  operand b for yAlu (register value or immediate).
out_op  out  3  yAlu op code.
out_rd  out  5  destination register, carried to writeback.
out_illegal  out  1  issued instruction was not a supported ALU operation.

Behaviour:
- Reset (rst=1 at a clock edge): all 32 registers become 0, all pending bits are cleared, out_valid=0, and out_a/out_b/out_op/out_rd/out_illegal are 0. Reset overrides any transfer in progress; a half-accepted instruction is dropped.
- Decode: opcode 0110011 is R-type, opcode 0010011 is I-type.
  - funct3 000 gives op=010 (add). In R-type with inst[30]=1 it gives op=110 (sub).
  - funct3 111 gives op=000 (and); funct3 110 gives op=001 (or); funct3 010 gives op=111 (slt).
- Immediate (I-type): out_b is inst[31:20] sign-extended to XLEN bits.
- Illegal instructions: any other opcode/funct3 combination issues with out_illegal=1, op=010, out_rd=0. It sets no pending bit.
- Register file: x0 always reads 0, and writes to x0 are discarded. On wb_en the value wb_data is written to wb_rd at the clock edge.
- Bypass: if a source equals wb_rd, wb_en=1 and wb_rd≠0 in the issue cycle, the operand takes wb_data instead of the register-file value.
- Scoreboard: each register has one pending bit.
  - It is set when an instruction with rd≠0 is accepted.
  - It is cleared by wb_en for that register.
  - If set and clear hit the same register in the same cycle, set wins.
- Hazard: raised when rs1 is pending, or (R-type and rs2 is pending), or rd≠0 and rd is pending.
  - A pending bit being cleared by writeback in the current cycle counts as not pending, so the bypass applies and no stall occurs.
- Handshake:
  - in_ready = !hazard && (!out_valid || out_ready).
  - An instruction is accepted when in_valid && in_ready. Its output appears with out_valid=1 on the next cycle, a latency of 1.
  - The output register is held stable while out_valid && !out_ready.
  - out_valid drops when the output is consumed and nothing new is accepted in the same cycle.
  - Back-to-back accept and consume in the same cycle sustains 1 instruction per cycle.
- Boundaries:
  - in_inst is a don't-care when in_valid=0.
  - A writeback to a non-pending register still writes.
  - The stage does not store the instruction internally during a stall; the source must hold in_inst until it is accepted.

Optional Feature:
ALU_ISSUE_STATS_EN
- When defined: adds output port stall_cnt [STALL_CW-1:0].
  - It increments every cycle in which in_valid && !in_ready.
  - It saturates at all-ones and is cleared by rst.
- When undefined: the port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then issue addi x1,x0,5 with out_ready=1 -> next cycle out_valid=1, out_a=0, out_b=5, out_op=010, out_rd=1, and pending[1] is set.
- Issue add x2,x1,x1 while pending[1] is set and there is no writeback -> in_ready=0. Then drive wb_en=1, wb_rd=1, wb_data=5 -> accepted that cycle with out_a=out_b=5 (bypass).
- Issue sub x3,x4,x5 with x4=9, x5=12 -> out_op=110, out_a=9, out_b=12. Issue slti x6,x4,-1 -> out_op=111, out_b=32'hFFFFFFFF.
- Hold out_ready=0 with out_valid=1 for 3 cycles -> outputs stay constant and in_ready=0. Raise out_ready -> the next instruction is accepted the same cycle.
- Issue a load word (opcode 0000011) -> out_illegal=1, out_rd=0, no pending bit set. A write to x0 via wb -> x0 still reads 0.
- With ALU_ISSUE_STATS_EN: stall 4 cycles on a hazard -> stall_cnt=4. Assert rst -> stall_cnt=0 and out_valid=0 on the next cycle.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Handshake and writeback bundle between the instruction source, the issue
// stage and the yAlu side. The slave modport is the issue stage's view; the
// master modport is the view of whatever drives instructions and writebacks.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [2:0]      out_op;
    logic [4:0]      out_rd;
    logic            out_illegal;

    modport master (
        output in_valid, in_inst, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_op, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_op, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Operand-fetch / issue stage in front of yAlu. Holds the integer register
// file, decodes RV32I R/I-type ALU instructions, blocks RAW/WAW hazards with a
// per-register pending scoreboard and presents operands in a single-entry
// output register with a valid/ready handshake.
// Optional build macro ALU_ISSUE_STATS_EN adds a saturating stall_cnt port.
module alu_issue_stage #(
    parameter int XLEN     = 32,
    parameter int STALL_CW = 16
) (
    input  logic clk,
    input  logic rst,
    alu_issue_stage_if.slave bus
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [STALL_CW-1:0] stall_cnt
`endif
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    logic [XLEN-1:0] regs [32];
    logic [31:0]     pending;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            is_r;
    logic            is_i;
    logic            legal;
    logic [2:0]      dec_op;
    logic [4:0]      rd_eff;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] opnd_b;
    logic [31:0]     wb_hit;
    logic [31:0]     busy;
    logic            hazard;
    logic            accept;

    logic            out_valid_q;
    logic [XLEN-1:0] out_a_q;
    logic [XLEN-1:0] out_b_q;
    logic [2:0]      out_op_q;
    logic [4:0]      out_rd_q;
    logic            out_illegal_q;

    assign opcode = bus.in_inst[6:0];
    assign funct3 = bus.in_inst[14:12];
    assign rs1    = bus.in_inst[19:15];
    assign rs2    = bus.in_inst[24:20];
    assign rd     = bus.in_inst[11:7];
    assign imm    = {{(XLEN-12){bus.in_inst[31]}}, bus.in_inst[31:20]};

    // Decode opcode/funct3 into the yAlu op; anything unsupported issues as an illegal add with no destination
    always_comb begin
        is_r   = (opcode == OPC_R);
        is_i   = (opcode == OPC_I);
        legal  = 1'b0;
        dec_op = 3'b010;
        if (is_r || is_i) begin
            case (funct3)
                3'b000: begin
                    legal  = 1'b1;
                    dec_op = (is_r && bus.in_inst[30]) ? 3'b110 : 3'b010;
                end
                3'b111: begin
                    legal  = 1'b1;
                    dec_op = 3'b000;
                end
                3'b110: begin
                    legal  = 1'b1;
                    dec_op = 3'b001;
                end
                3'b010: begin
                    legal  = 1'b1;
                    dec_op = 3'b111;
                end
                default: begin
                    legal  = 1'b0;
                    dec_op = 3'b010;
                end
            endcase
        end
        rd_eff = legal ? rd : 5'd0;
    end

    // One-hot view of this cycle's writeback; x0 writes never count as a hit
    always_comb begin
        wb_hit = '0;
        if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
            wb_hit[bus.wb_rd] = 1'b1;
        end
    end

    // A register being written back this cycle is treated as already free
    assign busy   = pending & ~wb_hit;
    assign hazard = busy[rs1] || (is_r && busy[rs2]) || ((rd_eff != 5'd0) && busy[rd_eff]);

    assign bus.in_ready = !hazard && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Source A read with writeback bypass; x0 is hardwired to zero
    always_comb begin
        if (rs1 == 5'd0) begin
            src_a = '0;
        end else if (wb_hit[rs1]) begin
            src_a = bus.wb_data;
        end else begin
            src_a = regs[rs1];
        end
    end

    // Source B read with writeback bypass; I-type replaces it with the immediate
    always_comb begin
        if (rs2 == 5'd0) begin
            src_b = '0;
        end else if (wb_hit[rs2]) begin
            src_b = bus.wb_data;
        end else begin
            src_b = regs[rs2];
        end
        opnd_b = is_i ? imm : src_b;
    end

    // Register file write port; entry 0 stays zero because wb_hit never selects it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wb_hit[i]) begin
                    regs[i] <= bus.wb_data;
                end
            end
        end
    end

    // Pending scoreboard: writeback clears, an accepted destination sets, and set wins a same-cycle tie
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (accept && (rd_eff == 5'(i))) begin
                    pending[i] <= 1'b1;
                end else if (wb_hit[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            pending[0] <= 1'b0;
        end
    end

    // Single-entry output register: load on accept, hold while stalled, empty once consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_op_q      <= 3'b000;
            out_rd_q      <= 5'd0;
            out_illegal_q <= 1'b0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_a_q       <= src_a;
            out_b_q       <= opnd_b;
            out_op_q      <= dec_op;
            out_rd_q      <= rd_eff;
            out_illegal_q <= !legal;
        end else if (bus.out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_a       = out_a_q;
    assign bus.out_b       = out_b_q;
    assign bus.out_op      = out_op_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_illegal = out_illegal_q;

`ifdef ALU_ISSUE_STATS_EN
    // Count cycles where the source offers an instruction that cannot be taken, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (bus.in_valid && !bus.in_ready && (stall_cnt != {STALL_CW{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(STALL_CW-1){1'b0}}, 1'b1};
        end
    end
`else
    logic unused_stall_cfg;
    assign unused_stall_cfg = (STALL_CW > 0);
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a driver issues directed and random
// instructions/writebacks, predicts acceptance from a register/pending model
// and queues the expected issue; a monitor compares the output register
// against the queue head every cycle it should be valid.
module tb_alu_issue_stage;

    localparam int XLEN     = 32;
    localparam int STALL_CW = 16;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst;

    alu_issue_stage_if #(.XLEN(XLEN)) bus ();

`ifdef ALU_ISSUE_STATS_EN
    logic [STALL_CW-1:0] stall_cnt;
`endif

    alu_issue_stage #(.XLEN(XLEN), .STALL_CW(STALL_CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    logic [31:0] mrf [32];
    bit   [31:0] mpend;
    int          mstall;
    int          errors = 0;
    int          checks = 0;
    bit          mon_on = 0;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input bit sub, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {1'b0, sub, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Architectural read as seen during the issue cycle, including same-cycle writeback
    function automatic logic [31:0] readReg(input logic [4:0] r, input logic we, input logic [4:0] wr,
                                            input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (we && wr == r) return wd;
        return mrf[r];
    endfunction

    function automatic bit isBusy(input logic [4:0] r, input logic we, input logic [4:0] wr);
        return (r != 5'd0) && mpend[r] && !(we && wr == r);
    endfunction

    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic we,
                                 input logic [4:0] wr, input logic [31:0] wd, input logic ordy,
                                 output bit accepted);
        logic [6:0] opc;
        logic [2:0] f3;
        bit         is_r;
        bit         is_i;
        bit         legal;
        bit         hz;
        bit         exp_ready;
        exp_t       e;
        @(negedge clk);
        rst           = 1'b0;
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.wb_en     = we;
        bus.wb_rd     = wr;
        bus.wb_data   = wd;
        bus.out_ready = ordy;
        #4;
        opc   = inst[6:0];
        f3    = inst[14:12];
        is_r  = (opc == 7'h33);
        is_i  = (opc == 7'h13);
        legal = (is_r || is_i) && (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd2);
        e.ill = !legal;
        e.rd  = legal ? inst[11:7] : 5'd0;
        if (!legal)          e.op = 3'b010;
        else if (f3 == 3'd0) e.op = (is_r && inst[30]) ? 3'b110 : 3'b010;
        else if (f3 == 3'd7) e.op = 3'b000;
        else if (f3 == 3'd6) e.op = 3'b001;
        else                 e.op = 3'b111;
        e.a = readReg(inst[19:15], we, wr, wd);
        e.b = is_i ? {{20{inst[31]}}, inst[31:20]} : readReg(inst[24:20], we, wr, wd);
        hz  = isBusy(inst[19:15], we, wr) || (is_r && isBusy(inst[24:20], we, wr)) || isBusy(e.rd, we, wr);
        exp_ready = !hz && (sb.size() == 0);
        checkOutput("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ready});
`ifdef ALU_ISSUE_STATS_EN
        checkOutput("stall_cnt", {48'd0, stall_cnt}, 64'(mstall));
`endif
        if (v && !exp_ready && mstall < (1 << STALL_CW) - 1) mstall++;
        accepted = v && exp_ready;
        if (accepted) sb.push_back(e);
        if (we && wr != 5'd0) begin
            mrf[wr]   = wd;
            mpend[wr] = 1'b0;
        end
        if (accepted && e.rd != 5'd0) mpend[e.rd] = 1'b1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'd0;
        bus.wb_en     = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.wb_data   = 32'd0;
        bus.out_ready = 1'b0;
        #4;
        sb.delete();
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        mpend  = '0;
        mstall = 0;
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("rst_out_a", {32'd0, bus.out_a}, 64'd0);
        checkOutput("rst_out_b", {32'd0, bus.out_b}, 64'd0);
        checkOutput("rst_out_op", {61'd0, bus.out_op}, 64'd0);
        checkOutput("rst_out_rd", {59'd0, bus.out_rd}, 64'd0);
        checkOutput("rst_out_illegal", {63'd0, bus.out_illegal}, 64'd0);
`ifdef ALU_ISSUE_STATS_EN
        checkOutput("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
`endif
    endtask

    function automatic logic [31:0] randInst();
        int          k;
        logic [31:0] w;
        logic [2:0]  f3s [4];
        f3s[0] = 3'd0; f3s[1] = 3'd7; f3s[2] = 3'd6; f3s[3] = 3'd2;
        k = $urandom_range(0, 9);
        if (k < 4)
            w = rtype(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      f3s[$urandom_range(0, 3)], 5'($urandom_range(0, 7)));
        else if (k < 8)
            w = itype(12'($urandom), 5'($urandom_range(0, 7)), f3s[$urandom_range(0, 3)],
                      5'($urandom_range(0, 7)));
        else if (k == 8)
            w = rtype(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        else begin
            w = $urandom;
            w[19:15] = 5'($urandom_range(0, 7));
        end
        return w;
    endfunction

    // Monitor: compare the output register with the oldest outstanding issue, retire it on consume
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!mon_on) continue;
            checkOutput("out_valid", {63'd0, bus.out_valid}, {63'd0, sb.size() != 0});
            if (sb.size() != 0) begin
                e = sb[0];
                checkOutput("out_op", {61'd0, bus.out_op}, {61'd0, e.op});
                checkOutput("out_rd", {59'd0, bus.out_rd}, {59'd0, e.rd});
                checkOutput("out_illegal", {63'd0, bus.out_illegal}, {63'd0, e.ill});
                if (!e.ill) begin
                    checkOutput("out_a", {32'd0, bus.out_a}, {32'd0, e.a});
                    checkOutput("out_b", {32'd0, bus.out_b}, {32'd0, e.b});
                end
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        bit          acc;
        bit          have;
        logic [31:0] cur;
        logic [31:0] add2;
        logic [31:0] addi9;
        logic [31:0] add13;
        logic        we;
        logic [4:0]  wr;
        int          k;
        int          start;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'd0;
        bus.wb_en     = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.wb_data   = 32'd0;
        bus.out_ready = 1'b0;
        doReset();
        mon_on = 1'b1;

        applyStimulus(1, itype(12'd5, 5'd0, 3'd0, 5'd1), 0, 0, 0, 1, acc);
        add2 = rtype(0, 5'd1, 5'd1, 3'd0, 5'd2);
        applyStimulus(1, add2, 0, 0, 0, 1, acc);
        applyStimulus(1, add2, 1, 5'd1, 32'd5, 1, acc);
        applyStimulus(0, 32'd0, 1, 5'd4, 32'd9, 1, acc);
        applyStimulus(0, 32'd0, 1, 5'd5, 32'd12, 1, acc);
        applyStimulus(1, rtype(1, 5'd5, 5'd4, 3'd0, 5'd3), 0, 0, 0, 1, acc);
        applyStimulus(1, itype(12'hFFF, 5'd4, 3'd2, 5'd6), 0, 0, 0, 1, acc);
        applyStimulus(1, itype(12'd1, 5'd0, 3'd0, 5'd7), 0, 0, 0, 1, acc);
        addi9 = itype(12'd3, 5'd0, 3'd0, 5'd9);
        for (int i = 0; i < 3; i++) applyStimulus(1, addi9, 0, 0, 0, 0, acc);
        applyStimulus(1, addi9, 0, 0, 0, 1, acc);
        applyStimulus(1, {12'd0, 5'd0, 3'b010, 5'd8, 7'b0000011}, 0, 0, 0, 1, acc);
        applyStimulus(1, rtype(0, 5'd8, 5'd8, 3'd0, 5'd10), 0, 0, 0, 1, acc);
        applyStimulus(0, 32'd0, 1, 5'd0, 32'hDEAD, 1, acc);
        applyStimulus(1, rtype(0, 5'd0, 5'd0, 3'd6, 5'd11), 0, 0, 0, 1, acc);
        add13 = rtype(0, 5'd2, 5'd2, 3'd7, 5'd13);
        for (int i = 0; i < 4; i++) applyStimulus(1, add13, 0, 0, 0, 1, acc);
        applyStimulus(1, add13, 1, 5'd2, 32'h1234_5678, 1, acc);
        applyStimulus(0, 32'd0, 0, 0, 0, 1, acc);
        doReset();

        have = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!have) begin
                cur  = randInst();
                have = 1;
            end
            we = 1'b0;
            wr = 5'd0;
            k  = $urandom_range(0, 9);
            if (k < 4 && mpend != 0) begin
                start = $urandom_range(0, 31);
                for (int j = 0; j < 32; j++) begin
                    if (!we && mpend[(start + j) % 32]) begin
                        we = 1'b1;
                        wr = 5'((start + j) % 32);
                    end
                end
            end else if (k == 4) begin
                we = 1'b1;
                wr = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 9) < 7)
                applyStimulus(1, cur, we, wr, $urandom, ($urandom_range(0, 9) < 7), acc);
            else
                applyStimulus(0, $urandom, we, wr, $urandom, ($urandom_range(0, 9) < 7), acc);
            if (acc) have = 0;
            if (i == 1500) doReset();
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) applyStimulus(0, 32'd0, 0, 0, 0, 1, acc);
        applyStimulus(0, 32'd0, 0, 0, 0, 1, acc);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain outstanding=%0d expected=0", sb.size());
        end
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
